gmii_rx_frame: RTL and testbench

- Byte-wide GMII receive-side frame parser for the HDMI-over-Ethernet path. It is the reader matching the GMII transmit framer.
- Strips preamble/SFD and filters on destination MAC and EtherType. Streams payload bytes with the FCS removed, checks CRC32, and reports per-frame good/bad status.
- Sits between the PHY RX pins (gmii_rxclk domain) and the payload reassembly FIFO feeding the TMDS output side.

---
 rtl/gmii_rx_pkg.sv | 12 +
 rtl/crc32_d8.sv | 19 +
 rtl/gmii_rx_frame.sv | 200 ++++++++++++++++++++
 tb/tb_gmii_rx_frame.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/gmii_rx_pkg.sv
// Shared state encoding and framing constants for the GMII receive parser
// and the CRC32 step shared with the transmit framer.
package gmii_rx_pkg;
  typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, PAYLOAD, DROP} state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;
  localparam int          HDR_LEN       = 14;
  localparam int          FCS_LEN       = 4;
endpackage

// File: rtl/crc32_d8.sv
// Ethernet CRC32 (reflected polynomial 32'hEDB88320) advanced by one byte,
// data consumed LSB first. Purely combinational.
module crc32_d8 (
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);
  logic [31:0] w_c;

  always_comb begin
    w_c = i_crc;
    for (int i = 0; i < 8; i++) begin
      if (w_c[0] ^ i_data[i]) w_c = {1'b0, w_c[31:1]} ^ 32'hEDB88320;
      else                    w_c = {1'b0, w_c[31:1]};
    end
  end

  assign o_crc = w_c;
endmodule

// File: rtl/gmii_rx_frame.sv
// GMII receive frame parser: strips preamble/SFD, filters on destination MAC
// and EtherType, streams payload without FCS and reports per-frame status.
//
// state    | meaning
// IDLE     | wait for rv rising with 8'h55
// PREAMBLE | consume 8'h55 run until SFD
// HEADER   | 14 header bytes, DA and EtherType filter
// PAYLOAD  | stream through the 4-byte FCS delay line
// DROP     | discard bytes until rv falls
module gmii_rx_frame
  import gmii_rx_pkg::*;
#(
  parameter logic [47:0] MY_MAC      = 48'h000A35000102,
  parameter logic [15:0] ETH_TYPE    = 16'h88B5,
  parameter int          MIN_PAYLOAD = 46,
  parameter int          MAX_PAYLOAD = 1500
) (
  input  logic        gmii_rxclk,
  input  logic        sys_rst,
  input  logic        gmii_rxdv,
  input  logic [7:0]  gmii_rxd,
  output logic [7:0]  pay_data,
  output logic        pay_valid,
  output logic        pay_sof,
  output logic        pay_eof,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
);
  localparam logic [10:0] LEN_MIN  = 11'(MIN_PAYLOAD + FCS_LEN);
  localparam logic [10:0] LEN_MAX  = 11'(MAX_PAYLOAD + FCS_LEN);
  localparam logic [10:0] LEN_OVF  = 11'(MAX_PAYLOAD + FCS_LEN + 1);
  localparam logic [10:0] FCS_CNT  = 11'(FCS_LEN);
  localparam logic [3:0]  HDR_LAST = 4'(HDR_LEN - 1);

  logic        r_rv, r_smp, r_prev_low;
  logic [7:0]  r_rd;
  state_t      r_state, w_state_n;
  logic [31:0] r_crc, w_crc_n, w_crc_calc;
  logic [3:0]  r_hcnt, w_hcnt_n;
  logic [10:0] r_pcnt, w_pcnt_n;
  logic        r_uc, w_uc_n, r_bc, w_bc_n;
  logic [31:0] r_dl, w_dl_n;
  logic [7:0]  r_pay_data, w_pay_data_n;
  logic        r_pay_valid, w_pay_valid_n, r_pay_sof, w_pay_sof_n;
  logic        r_pay_eof, w_pay_eof_n, r_ok, w_ok_n, r_err, w_err_n, w_trunc;
  logic [15:0] r_frame_cnt, r_err_cnt;
  logic [47:0] w_mac_sh;

  assign w_mac_sh = MY_MAC << {r_hcnt, 3'b000};

  crc32_d8 u_crc (.i_crc(r_crc), .i_data(r_rd), .o_crc(w_crc_calc));

  // r_prev_low only trusts r_rv once it holds a real sample, so a frame
  // already running at reset release cannot look like a fresh start.
  always_ff @(posedge gmii_rxclk or posedge sys_rst) begin
    if (sys_rst) begin
      r_rv       <= 1'b0;
      r_rd       <= 8'h00;
      r_smp      <= 1'b0;
      r_prev_low <= 1'b0;
    end else begin
      r_rv       <= gmii_rxdv;
      r_rd       <= gmii_rxd;
      r_smp      <= 1'b1;
      r_prev_low <= r_smp & ~r_rv;
    end
  end

  always_ff @(posedge gmii_rxclk or posedge sys_rst) begin
    if (sys_rst) r_state <= IDLE;
    else         r_state <= w_state_n;
  end

  always_comb begin
    w_state_n     = r_state;
    w_crc_n       = r_crc;
    w_hcnt_n      = r_hcnt;
    w_pcnt_n      = r_pcnt;
    w_uc_n        = r_uc;
    w_bc_n        = r_bc;
    w_dl_n        = r_dl;
    w_pay_data_n  = r_pay_data;
    w_pay_valid_n = 1'b0;
    w_pay_sof_n   = 1'b0;
    w_pay_eof_n   = 1'b0;
    w_ok_n        = 1'b0;
    w_err_n       = 1'b0;
    w_trunc       = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_rv && r_rd == PREAMBLE_BYTE && r_prev_low) w_state_n = PREAMBLE;
      end
      PREAMBLE: begin
        if (!r_rv) w_state_n = IDLE;
        else if (r_rd == SFD_BYTE) begin
          w_state_n = HEADER;
          w_crc_n   = CRC_INIT;
          w_hcnt_n  = 4'd0;
          w_uc_n    = 1'b1;
          w_bc_n    = 1'b1;
        end else if (r_rd != PREAMBLE_BYTE) w_state_n = DROP;
      end
      HEADER: begin
        if (!r_rv) begin
          w_state_n = IDLE;
          w_trunc   = 1'b1;
        end else begin
          w_crc_n  = w_crc_calc;
          w_hcnt_n = r_hcnt + 4'd1;
          if (r_hcnt < 4'd6) begin
            if (r_rd != w_mac_sh[47:40]) w_uc_n = 1'b0;
            if (r_rd != 8'hFF)           w_bc_n = 1'b0;
            if (!w_uc_n && !w_bc_n)      w_state_n = DROP;
          end else if (r_hcnt == HDR_LAST - 4'd1) begin
            if (r_rd != ETH_TYPE[15:8]) w_state_n = DROP;
          end else if (r_hcnt == HDR_LAST) begin
            if (r_rd != ETH_TYPE[7:0]) w_state_n = DROP;
            else begin
              w_state_n = PAYLOAD;
              w_pcnt_n  = 11'd0;
            end
          end
        end
      end
      PAYLOAD: begin
        if (!r_rv) begin
          w_state_n = IDLE;
          if (r_pcnt <= FCS_CNT) w_trunc = 1'b1;
          else begin
            w_pay_eof_n = 1'b1;
            if (r_crc == CRC_RESIDUE && r_pcnt >= LEN_MIN && r_pcnt <= LEN_MAX) w_ok_n = 1'b1;
            else w_err_n = 1'b1;
          end
        end else begin
          w_crc_n  = w_crc_calc;
          w_pcnt_n = r_pcnt + 11'd1;
          w_dl_n   = {r_dl[23:0], r_rd};
          if (r_pcnt + 11'd1 == LEN_OVF) begin
            w_state_n   = DROP;
            w_pay_eof_n = 1'b1;
            w_err_n     = 1'b1;
          end else if (r_pcnt >= FCS_CNT) begin
            w_pay_valid_n = 1'b1;
            w_pay_data_n  = r_dl[31:24];
            w_pay_sof_n   = (r_pcnt == FCS_CNT);
          end
        end
      end
      DROP: begin
        if (!r_rv) w_state_n = IDLE;
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge gmii_rxclk or posedge sys_rst) begin
    if (sys_rst) begin
      r_crc       <= CRC_INIT;
      r_hcnt      <= 4'd0;
      r_pcnt      <= 11'd0;
      r_uc        <= 1'b0;
      r_bc        <= 1'b0;
      r_dl        <= 32'h0;
      r_pay_data  <= 8'h00;
      r_pay_valid <= 1'b0;
      r_pay_sof   <= 1'b0;
      r_pay_eof   <= 1'b0;
      r_ok        <= 1'b0;
      r_err       <= 1'b0;
      r_frame_cnt <= 16'h0;
      r_err_cnt   <= 16'h0;
    end else begin
      r_crc       <= w_crc_n;
      r_hcnt      <= w_hcnt_n;
      r_pcnt      <= w_pcnt_n;
      r_uc        <= w_uc_n;
      r_bc        <= w_bc_n;
      r_dl        <= w_dl_n;
      r_pay_data  <= w_pay_data_n;
      r_pay_valid <= w_pay_valid_n;
      r_pay_sof   <= w_pay_sof_n;
      r_pay_eof   <= w_pay_eof_n;
      r_ok        <= w_ok_n;
      r_err       <= w_err_n;
      if (w_ok_n && r_frame_cnt != 16'hFFFF) r_frame_cnt <= r_frame_cnt + 16'd1;
      if ((w_err_n || w_trunc) && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign pay_data  = r_pay_data;
  assign pay_valid = r_pay_valid;
  assign pay_sof   = r_pay_sof;
  assign pay_eof   = r_pay_eof;
  assign frame_ok  = r_ok;
  assign frame_err = r_err;
  assign frame_cnt = r_frame_cnt;
  assign err_cnt   = r_err_cnt;
endmodule

// File: tb/tb_gmii_rx_frame.sv
// Scoreboard bench for gmii_rx_frame: frames are built with their own CRC,
// expected payload bytes and end status are queued as they are driven.
module tb_gmii_rx_frame;
  localparam logic [47:0] MY_MAC   = 48'h000A35000102;
  localparam logic [47:0] BCAST    = 48'hFFFFFFFFFFFF;
  localparam logic [15:0] ETH_TYPE = 16'h88B5;

  typedef struct {logic [7:0] d; logic sof; int cyc;} pay_t;
  typedef struct {logic ok; logic err; int cyc;} eof_t;

  logic        gmii_rxclk = 1'b0;
  logic        sys_rst    = 1'b1;
  logic        gmii_rxdv  = 1'b0;
  logic [7:0]  gmii_rxd   = 8'h00;
  logic [7:0]  pay_data;
  logic        pay_valid, pay_sof, pay_eof, frame_ok, frame_err;
  logic [15:0] frame_cnt, err_cnt;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_mis = 0;
  int   m_fc = 0;
  int   m_ec = 0;
  bit   sb_off = 1'b0;
  pay_t exp_q[$];
  eof_t eof_q[$];
  logic [7:0] fb[$];

  gmii_rx_frame dut (
    .gmii_rxclk(gmii_rxclk), .sys_rst(sys_rst),
    .gmii_rxdv(gmii_rxdv), .gmii_rxd(gmii_rxd),
    .pay_data(pay_data), .pay_valid(pay_valid), .pay_sof(pay_sof),
    .pay_eof(pay_eof), .frame_ok(frame_ok), .frame_err(frame_err),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  always #4 gmii_rxclk = ~gmii_rxclk;
  always @(posedge gmii_rxclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int j = 0; j < 8; j++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic drive(input logic v, input logic [7:0] d);
    @(posedge gmii_rxclk);
    #1;
    gmii_rxdv = v;
    gmii_rxd  = d;
  endtask

  task automatic build(input logic [47:0] dst, input logic [15:0] et, input int plen,
                       input int flip, input int seed);
    logic [31:0] c;
    int idx;
    fb.delete();
    for (int i = 0; i < 6; i++) fb.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) fb.push_back((i == 0) ? 8'h02 : 8'(i));
    fb.push_back(et[15:8]);
    fb.push_back(et[7:0]);
    for (int k = 0; k < plen; k++) fb.push_back(8'(k * 37 + seed * 11 + 5));
    c = 32'hFFFFFFFF;
    foreach (fb[i]) c = crc_byte(c, fb[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) fb.push_back(c[8*i +: 8]);
    if (flip >= 0) begin
      idx = 14 + flip / 8;
      fb[idx] = fb[idx] ^ (8'h01 << (flip % 8));
    end
  endtask

  // cut >= 0 sends only the header plus cut bytes and then drops rv.
  task automatic send(input logic [47:0] dst, input logic [15:0] et, input int plen,
                      input int flip, input int cut, input int gap, input int seed);
    bit acc, ok;
    int total, streamed, k;
    build(dst, et, plen, flip, seed);
    acc      = (dst == MY_MAC || dst == BCAST) && et == ETH_TYPE;
    total    = (cut >= 0) ? cut : plen + 4;
    streamed = (total >= 1505) ? 1500 : (total > 4) ? total - 4 : 0;
    ok       = (flip < 0) && (cut < 0) && plen >= 46 && plen <= 1500;
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    for (int i = 0; i < 14 + total; i++) begin
      drive(1'b1, fb[i]);
      if (acc && i >= 14) begin
        k = i - 14;
        if (k < streamed) exp_q.push_back('{fb[i], (k == 0), cyc + 6});
        if (k == 1504) eof_q.push_back('{1'b0, 1'b1, cyc + 2});
      end
    end
    drive(1'b0, 8'h00);
    if (acc) begin
      if (total > 4 && total < 1505) eof_q.push_back('{ok, !ok, cyc + 2});
      if (ok) m_fc++;
      else    m_ec++;
    end
    for (int i = 1; i < gap; i++) drive(1'b0, 8'h00);
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    repeat (4) @(posedge gmii_rxclk);
    while ((exp_q.size() != 0 || eof_q.size() != 0) && t < 100) begin
      @(posedge gmii_rxclk);
      t++;
    end
    @(negedge gmii_rxclk);
    chk({tag, "_pending"}, 32'(exp_q.size() + eof_q.size()), 32'd0);
    exp_q.delete();
    eof_q.delete();
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(m_fc));
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(m_ec));
  endtask

  always @(negedge gmii_rxclk) begin
    if (!sys_rst && !sb_off) begin
      if (pay_valid || pay_eof) chk("valid_eof_excl", 32'(pay_valid & pay_eof), 32'd0);
      if (frame_ok || frame_err) begin
        chk("status_with_eof", 32'(pay_eof), 32'd1);
        chk("ok_err_excl", 32'(frame_ok & frame_err), 32'd0);
      end
      if (pay_sof && !pay_valid) chk("sof_without_valid", 32'(pay_valid), 32'd1);
      if (pay_valid) begin
        if (exp_q.size() == 0) chk("unexpected_valid", 32'(exp_q.size()), 32'd1);
        else begin
          pay_t e;
          e = exp_q.pop_front();
          chk("pay_data", 32'(pay_data), 32'(e.d));
          chk("pay_sof", 32'(pay_sof), 32'(e.sof));
          chk("pay_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (pay_eof) begin
        if (eof_q.size() == 0) chk("unexpected_eof", 32'(eof_q.size()), 32'd1);
        else begin
          eof_t f;
          f = eof_q.pop_front();
          chk("frame_ok", 32'(frame_ok), 32'(f.ok));
          chk("frame_err", 32'(frame_err), 32'(f.err));
          chk("eof_cycle", 32'(cyc), 32'(f.cyc));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge gmii_rxclk);
    #1;
    chk("rst_outputs", {22'd0, pay_data, pay_valid, pay_sof, pay_eof, frame_ok, frame_err}, 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    sys_rst = 1'b0;
    repeat (3) drive(1'b0, 8'h00);

    send(MY_MAC, ETH_TYPE, 60, -1, -1, 12, 1);            drain("good60");
    send(MY_MAC, ETH_TYPE, 60, 100, -1, 12, 1);           drain("bitflip");
    send(48'h000A35000199, ETH_TYPE, 60, -1, -1, 12, 2);  drain("bad_da");
    send(MY_MAC, 16'h0800, 60, -1, -1, 12, 3);            drain("bad_type");
    send(BCAST, ETH_TYPE, 60, -1, -1, 12, 4);             drain("bcast");
    send(MY_MAC, ETH_TYPE, 46, -1, -1, 12, 5);            drain("min46");
    send(MY_MAC, ETH_TYPE, 45, -1, -1, 12, 6);            drain("short45");
    send(MY_MAC, ETH_TYPE, 1500, -1, -1, 12, 7);          drain("max1500");
    send(MY_MAC, ETH_TYPE, 1501, -1, -1, 12, 8);          drain("over1501");
    send(MY_MAC, ETH_TYPE, 20, -1, -1, 12, 9);            drain("runt20");
    send(MY_MAC, ETH_TYPE, 60, -1, 4, 12, 10);            drain("trunc4");
    send(MY_MAC, ETH_TYPE, 60, -1, 5, 12, 11);            drain("trunc5");
    send(MY_MAC, ETH_TYPE, 60, -1, -1, 1, 12);
    send(MY_MAC, ETH_TYPE, 100, -1, -1, 12, 13);          drain("b2b");

    // reset in the middle of a payload, released while rv stays high
    sb_off = 1'b1;
    build(MY_MAC, ETH_TYPE, 60, -1, 14);
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    for (int i = 0; i < 44; i++) drive(1'b1, fb[i]);
    #2 sys_rst = 1'b1;
    #1;
    chk("midrst_outputs", {22'd0, pay_data, pay_valid, pay_sof, pay_eof, frame_ok, frame_err}, 32'd0);
    chk("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("midrst_err_cnt", 32'(err_cnt), 32'd0);
    m_fc = 0;
    m_ec = 0;
    exp_q.delete();
    eof_q.delete();
    drive(1'b1, fb[44]);
    drive(1'b1, fb[45]);
    sys_rst = 1'b0;
    sb_off  = 1'b0;
    for (int i = 46; i < fb.size(); i++) drive(1'b1, fb[i]);
    drive(1'b1, 8'h55);
    drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    drive(1'b0, 8'h00);
    drain("after_rst");
    send(MY_MAC, ETH_TYPE, 60, -1, -1, 12, 15);           drain("clean");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
